// File: rtl/inst_sram_responder_pkg.sv
// rtl/inst_sram_responder_pkg.sv - shared bus widths and response FSM encoding
package inst_sram_responder_pkg;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int WORD_ADDR_W = ADDR_W - 2;
    localparam int LAT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RD   = 2'd2,
        ST_RESP = 2'd3
    } resp_state_t;

endpackage

// File: rtl/inst_req_fifo.sv
// rtl/inst_req_fifo.sv - in-order queue of accepted fetch word addresses
module inst_req_fifo
    import inst_sram_responder_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = WORD_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Entry storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_sram_responder.sv
// rtl/inst_sram_responder.sv - instruction SRAM responder with request queue and read-latency FSM
module inst_sram_responder
    import inst_sram_responder_pkg::*;
#(
    parameter int LAT   = 0,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inst_sram_req_i,
    input  logic [ADDR_W-1:0]      inst_sram_raddr_i,
    input  logic                   delay_en_i,
    output logic                   inst_sram_addr_ok_o,
    output logic                   inst_sram_data_ok_o,
    output logic [DATA_W-1:0]      inst_sram_rdata_o,
    output logic                   mem_en_o,
    output logic [WORD_ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0]      mem_rdata_i
);
    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam int                LAT_M1_I = (LAT > 0) ? LAT - 1 : 0;
    localparam logic [LAT_W-1:0]  LAT_M1   = LAT_W'(LAT_M1_I);

    resp_state_t            state;
    logic [LAT_W-1:0]       cnt;
    logic                   mem_en_q;
    logic                   data_ok_q;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic                   more_work;
    logic [WORD_ADDR_W-1:0] head;
    logic [CNT_W-1:0]       count;
    logic                   unused_byte_offset;

    assign unused_byte_offset  = ^inst_sram_raddr_i[1:0];
    assign inst_sram_addr_ok_o = rst_n & ~full & ~delay_en_i;
    assign push                = inst_sram_req_i & inst_sram_addr_ok_o;
    assign pop                 = data_ok_q;

    // A same-cycle push is queued work too, so an idle responder or a RESP pop starts the next read without a bubble.
    always_comb begin
        more_work = push;
        if (state == ST_RESP) begin
            more_work = push | (count > CNT_W'(1));
        end else begin
            more_work = push | ~empty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mem_en_q  <= 1'b0;
            data_ok_q <= 1'b0;
        end else begin
            mem_en_q  <= 1'b0;
            data_ok_q <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (more_work) begin
                        if (LAT > 0) begin
                            state <= ST_WAIT;
                            cnt   <= LAT_M1;
                        end else begin
                            state    <= ST_RD;
                            mem_en_q <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state    <= ST_RD;
                        mem_en_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RD: begin
                    state     <= ST_RESP;
                    data_ok_q <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    inst_req_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_ADDR_W)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (inst_sram_raddr_i[ADDR_W-1:2]),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head),
        .count     (count)
    );

    assign mem_en_o            = mem_en_q;
    assign mem_addr_o          = mem_en_q ? head : '0;
    assign inst_sram_data_ok_o = data_ok_q;
    assign inst_sram_rdata_o   = data_ok_q ? mem_rdata_i : '0;

endmodule

// File: tb/tb_inst_sram_responder.sv
// tb/tb_inst_sram_responder.sv - bench for inst_sram_responder (LAT=0/DEPTH=2 and LAT=3/DEPTH=4 instances)
module tb_inst_sram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       req;
    logic [1:0]       dly;
    logic [31:0]      raddr [2];
    logic [1:0]       addr_ok;
    logic [1:0]       data_ok;
    logic [1:0]       mem_en;
    logic [1:0][31:0] rdata;
    logic [1:0][31:0] mem_rdata;
    logic [1:0][29:0] mem_addr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    int pending [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_word(input logic [29:0] a);
        return {a, 2'b00} * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    function automatic int lat_of(input int s);
        return (s == 0) ? 0 : 3;
    endfunction

    function automatic int depth_of(input int s);
        return (s == 0) ? 2 : 4;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] ram_q;

        inst_sram_responder #(
            .LAT   (g == 0 ? 0 : 3),
            .DEPTH (g == 0 ? 2 : 4)
        ) u_dut (
            .clk                 (clk),
            .rst_n               (rst_n),
            .inst_sram_req_i     (req[g]),
            .inst_sram_raddr_i   (raddr[g]),
            .delay_en_i          (dly[g]),
            .inst_sram_addr_ok_o (addr_ok[g]),
            .inst_sram_data_ok_o (data_ok[g]),
            .inst_sram_rdata_o   (rdata[g]),
            .mem_en_o            (mem_en[g]),
            .mem_addr_o          (mem_addr[g]),
            .mem_rdata_i         (mem_rdata[g])
        );

        always @(posedge clk) if (mem_en[g]) ram_q <= ram_word(mem_addr[g]);
        assign mem_rdata[g] = ram_q;
    end

    // Reference: each accepted request answers at max(accept cycle, previous answer) + 2 + LAT.
    logic [31:0] q_addr [2][$];
    int          q_resp [2][$];
    int          last_resp [2];

    always @(negedge clk) begin
        if (mon_en) begin
            for (int s = 0; s < 2; s++) begin
                logic exp_ok, exp_dok, exp_men;
                int   r;
                exp_ok  = rst_n && !dly[s] && (q_addr[s].size() < depth_of(s));
                exp_dok = (q_resp[s].size() > 0) && (q_resp[s][0] == cyc);
                exp_men = (q_resp[s].size() > 0) && (q_resp[s][0] == cyc + 1);
                checks++;
                if (addr_ok[s] !== exp_ok) begin
                    errors++;
                    $display("FAIL mon_addr_ok[%0d] cyc %0d: got %b expected %b", s, cyc, addr_ok[s], exp_ok);
                end
                checks++;
                if (data_ok[s] !== exp_dok) begin
                    errors++;
                    $display("FAIL mon_data_ok[%0d] cyc %0d: got %b expected %b", s, cyc, data_ok[s], exp_dok);
                end
                if (exp_dok) begin
                    checks++;
                    if (rdata[s] !== ram_word(q_addr[s][0][31:2])) begin
                        errors++;
                        $display("FAIL mon_rdata[%0d] cyc %0d: got %h expected %h", s, cyc, rdata[s], ram_word(q_addr[s][0][31:2]));
                    end
                end
                checks++;
                if (mem_en[s] !== exp_men) begin
                    errors++;
                    $display("FAIL mon_mem_en[%0d] cyc %0d: got %b expected %b", s, cyc, mem_en[s], exp_men);
                end
                if (exp_men) begin
                    checks++;
                    if (mem_addr[s] !== q_addr[s][0][31:2]) begin
                        errors++;
                        $display("FAIL mon_mem_addr[%0d] cyc %0d: got %h expected %h", s, cyc, mem_addr[s], q_addr[s][0][31:2]);
                    end
                end
                if (exp_dok) begin
                    void'(q_addr[s].pop_front());
                    void'(q_resp[s].pop_front());
                end
                if (req[s] && exp_ok) begin
                    r = ((cyc > last_resp[s]) ? cyc : last_resp[s]) + 2 + lat_of(s);
                    q_addr[s].push_back(raddr[s]);
                    q_resp[s].push_back(r);
                    last_resp[s] = r;
                end
                if (!rst_n) begin
                    q_addr[s].delete();
                    q_resp[s].delete();
                    last_resp[s] = 0;
                end
                pending[s] = q_addr[s].size();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req      = 2'b00;
        dly      = 2'b00;
        raddr[0] = '0;
        raddr[1] = '0;
        tick();
        tick();
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (addr_ok[s] !== 1'b0 || data_ok[s] !== 1'b0 || mem_en[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: got addr_ok=%b data_ok=%b mem_en=%b expected all 0", s, addr_ok[s], data_ok[s], mem_en[s]);
            end
            checks++;
            if (rdata[s] !== 32'h0 || mem_addr[s] !== 30'h0) begin
                errors++;
                $display("FAIL reset_data[%0d]: got rdata=%h mem_addr=%h expected 0", s, rdata[s], mem_addr[s]);
            end
        end
        mon_en = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req[0]   = 1'b1;
        raddr[0] = 32'h1C00_0000;
        @(negedge clk);
        checks++;
        if (addr_ok[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: got %b expected 1", addr_ok[0]);
        end
        tick();
        req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_en[0] !== 1'b1 || mem_addr[0] !== 30'h0700_0000) begin
            errors++;
            $display("FAIL single_mem: got en=%b addr=%h expected en=1 addr=07000000", mem_en[0], mem_addr[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== ram_word(30'h0700_0000)) begin
            errors++;
            $display("FAIL single_resp: got ok=%b data=%h expected ok=1 data=%h", data_ok[0], rdata[0], ram_word(30'h0700_0000));
        end
        tick();
        @(negedge clk);
        checks++;
        if (data_ok[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: got data_ok=%b expected 0", data_ok[0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
        logic        exp_ok [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] got [$];
        int          idx = 0;
        logic        accepted;
        req[0]   = 1'b1;
        raddr[0] = addrs[0];
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 4) begin
                checks++;
                if (addr_ok[0] !== exp_ok[c]) begin
                    errors++;
                    $display("FAIL b2b_addr_ok cycle %0d: got %b expected %b", c, addr_ok[0], exp_ok[c]);
                end
            end
            if (data_ok[0]) got.push_back(rdata[0]);
            accepted = req[0] && addr_ok[0];
            tick();
            if (accepted) begin
                idx++;
                if (idx < 3) raddr[0] = addrs[idx];
                else req[0] = 1'b0;
            end
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses expected 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== ram_word(addrs[i][31:2])) begin
                errors++;
                $display("FAIL b2b_order[%0d]: got %h expected %h", i, got[i], ram_word(addrs[i][31:2]));
            end
        end
    endtask

    task automatic test_latency();
        logic [31:0] a;
        int          men = 0;
        int          dcyc = -1;
        a        = $urandom;
        req[1]   = 1'b1;
        raddr[1] = a;
        @(negedge clk);
        checks++;
        if (addr_ok[1] !== 1'b1) begin
            errors++;
            $display("FAIL lat3_accept: got %b expected 1", addr_ok[1]);
        end
        tick();
        req[1] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_en[1]) men++;
            if (data_ok[1] && dcyc < 0) begin
                dcyc = c;
                checks++;
                if (rdata[1] !== ram_word(a[31:2])) begin
                    errors++;
                    $display("FAIL lat3_rdata: got %h expected %h", rdata[1], ram_word(a[31:2]));
                end
            end
            tick();
        end
        checks++;
        if (dcyc != 5) begin
            errors++;
            $display("FAIL lat3_latency: got %0d expected 5", dcyc);
        end
        checks++;
        if (men != 1) begin
            errors++;
            $display("FAIL lat3_mem_en_count: got %0d expected 1", men);
        end
    endtask

    task automatic test_delay();
        req[0]   = 1'b1;
        raddr[0] = $urandom;
        dly[0]   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (addr_ok[0] !== 1'b0 || data_ok[0] !== 1'b0) begin
                errors++;
                $display("FAIL delay_block cycle %0d: got addr_ok=%b data_ok=%b expected 0 0", c, addr_ok[0], data_ok[0]);
            end
            tick();
        end
        dly[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (addr_ok[0] !== 1'b1) begin
            errors++;
            $display("FAIL delay_release: got %b expected 1", addr_ok[0]);
        end
        tick();
        req[0] = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_push_pop();
        logic [31:0] a;
        logic [31:0] b;
        a        = $urandom;
        b        = $urandom;
        req[0]   = 1'b1;
        raddr[0] = a;
        tick();
        req[0] = 1'b0;
        tick();
        req[0]   = 1'b1;
        raddr[0] = b;
        @(negedge clk);
        checks++;
        if (data_ok[0] !== 1'b1 || addr_ok[0] !== 1'b1) begin
            errors++;
            $display("FAIL pushpop_overlap: got data_ok=%b addr_ok=%b expected 1 1", data_ok[0], addr_ok[0]);
        end
        tick();
        req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_en[0] !== 1'b1 || mem_addr[0] !== b[31:2] || addr_ok[0] !== 1'b1) begin
            errors++;
            $display("FAIL pushpop_rd: got en=%b addr=%h addr_ok=%b expected 1 %h 1", mem_en[0], mem_addr[0], addr_ok[0], b[31:2]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (data_ok[0] !== 1'b1 || rdata[0] !== ram_word(b[31:2])) begin
            errors++;
            $display("FAIL pushpop_resp: got ok=%b data=%h expected 1 %h", data_ok[0], rdata[0], ram_word(b[31:2]));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        req[1]   = 1'b1;
        raddr[1] = $urandom;
        tick();
        raddr[1] = $urandom;
        tick();
        req[1] = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        checks++;
        if (data_ok[1] !== 1'b0 || mem_en[1] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_wait: got data_ok=%b mem_en=%b expected 0 0", data_ok[1], mem_en[1]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (addr_ok[1] !== 1'b0 || data_ok[1] !== 1'b0 || mem_en[1] !== 1'b0 || rdata[1] !== 32'h0 || mem_addr[1] !== 30'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got ok=%b dok=%b en=%b rdata=%h addr=%h expected all 0",
                     addr_ok[1], data_ok[1], mem_en[1], rdata[1], mem_addr[1]);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (data_ok[1] !== 1'b0 || mem_en[1] !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_discard cycle %0d: got data_ok=%b mem_en=%b expected 0 0", c, data_ok[1], mem_en[1]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int   acc [2] = '{0, 0};
        int   rsp [2] = '{0, 0};
        logic accepted [2] = '{1'b0, 1'b0};
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < 2; s++) begin
                if (!req[s] || accepted[s]) begin
                    req[s]   = ($urandom_range(0, 2) != 0);
                    raddr[s] = $urandom;
                end
                dly[s] = ($urandom_range(0, 4) == 0);
            end
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                accepted[s] = req[s] && addr_ok[s];
                if (accepted[s]) acc[s]++;
                if (data_ok[s]) rsp[s]++;
            end
            tick();
        end
        req = 2'b00;
        dly = 2'b00;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) if (data_ok[s]) rsp[s]++;
            tick();
        end
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (acc[s] == 0 || acc[s] != rsp[s] || pending[s] != 0) begin
                errors++;
                $display("FAIL random_drain[%0d]: got accepts=%0d responses=%0d pending=%0d expected equal nonzero counts and 0 pending",
                         s, acc[s], rsp[s], pending[s]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_latency();
        test_delay();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
